control_sequencer: RTL and testbench

Instruction-side counterpart of the Datapath: accepts 32-bit LEGv8 instructions over a valid/ready handshake, decodes them and drives the Datapath control word (SA, SB, DA, RegWrite, MemWrite, FS, SD), Const and Bsel for exactly one execute cycle per instruction. It also captures Datapath status into an architectural flags register for flag-setting ops. It sits between an instruction source (fetch unit or bench) and the Datapath.

---
 rtl/control_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// LEGv8 control sequencer: valid/ready instruction intake, decode, one EXEC cycle of Datapath control.
// Optional flag-setting ops (ADDS/SUBS) and the flags register are enabled by defining FLAG_SET_EN.
module control_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [4:0]  FS,
    output logic        SD,
    output logic [63:0] Const,
    output logic        Bsel,
    input  logic [3:0]  status,
    output logic [3:0]  flags,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;

    typedef struct packed {
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic        regwrite;
        logic        memwrite;
        logic [4:0]  fs;
        logic        sd;
        logic [63:0] konst;
        logic        bsel;
    } ctrl_t;

    localparam ctrl_t SAFE_CTRL = '{sa: 5'd31, sb: 5'd31, da: 5'd31, regwrite: 1'b0,
                                    memwrite: 1'b0, fs: 5'd0, sd: 1'b0, konst: 64'd0,
                                    bsel: 1'b0};

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
`ifdef FLAG_SET_EN
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
`endif

    state_t      state, state_nx;
    logic [31:0] ir;
    ctrl_t       ctrl_q, dec, ctrl_out;
    logic        dec_legal;
    logic        accept;

    // Register-register form: SA=Rn, SB=Rm, DA=Rd, result written back.
    function automatic ctrl_t dec_r(input logic [31:0] w, input logic [4:0] fs);
        ctrl_t c;
        c          = SAFE_CTRL;
        c.sa       = w[9:5];
        c.sb       = w[20:16];
        c.da       = w[4:0];
        c.fs       = fs;
        c.regwrite = 1'b1;
        return c;
    endfunction

    // Immediate form: Const replaces the B operand.
    function automatic ctrl_t dec_i(input logic [31:0] w, input logic [4:0] fs,
                                    input logic [63:0] k);
        ctrl_t c;
        c          = SAFE_CTRL;
        c.sa       = w[9:5];
        c.da       = w[4:0];
        c.fs       = fs;
        c.konst    = k;
        c.bsel     = 1'b1;
        c.regwrite = 1'b1;
        return c;
    endfunction

    logic [10:0] opc11;
    logic [9:0]  opc10;
    logic [63:0] imm12_z, shamt_z, imm9_s;

    assign opc11   = ir[31:21];
    assign opc10   = ir[31:22];
    assign imm12_z = {52'd0, ir[21:10]};
    assign shamt_z = {58'd0, ir[15:10]};
    assign imm9_s  = {{55{ir[20]}}, ir[20:12]};

`ifdef FLAG_SET_EN
    logic dec_setf;
    logic setf_q;
`endif

    always_comb begin
        dec       = SAFE_CTRL;
        dec_legal = 1'b1;
`ifdef FLAG_SET_EN
        dec_setf  = 1'b0;
`endif
        if (opc10 == OP_ADDI) begin
            dec = dec_i(ir, FS_ADD, imm12_z);
        end else if (opc10 == OP_SUBI) begin
            dec = dec_i(ir, FS_SUB, imm12_z);
        end else begin
            case (opc11)
                OP_ADD:  dec = dec_r(ir, FS_ADD);
                OP_SUB:  dec = dec_r(ir, FS_SUB);
                OP_AND:  dec = dec_r(ir, FS_AND);
                OP_ORR:  dec = dec_r(ir, FS_ORR);
                OP_EOR:  dec = dec_r(ir, FS_EOR);
                OP_LSL:  dec = dec_i(ir, FS_LSL, shamt_z);
                OP_LSR:  dec = dec_i(ir, FS_LSR, shamt_z);
                OP_LDUR: begin
                    dec    = dec_i(ir, FS_ADD, imm9_s);
                    dec.sd = 1'b1;
                end
                // Store: Rt travels on the B port as store data, nothing written back.
                OP_STUR: begin
                    dec          = dec_i(ir, FS_ADD, imm9_s);
                    dec.da       = 5'd31;
                    dec.sb       = ir[4:0];
                    dec.sd       = 1'b1;
                    dec.regwrite = 1'b0;
                    dec.memwrite = 1'b1;
                end
`ifdef FLAG_SET_EN
                OP_ADDS: begin
                    dec      = dec_r(ir, FS_ADD);
                    dec_setf = 1'b1;
                end
                OP_SUBS: begin
                    dec      = dec_r(ir, FS_SUB);
                    dec_setf = 1'b1;
                end
`endif
                default: dec_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nx = DECODE;
            end
            DECODE: state_nx = dec_legal ? EXEC : IDLE;
            EXEC: begin
                instr_ready = 1'b1;
                state_nx    = instr_valid ? DECODE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        accept = instr_valid && instr_ready;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ir      <= '0;
            ctrl_q  <= SAFE_CTRL;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nx;
            done    <= (state == EXEC);
            illegal <= (state == DECODE) && !dec_legal;
            if (accept) ir <= instr;
            if (state == DECODE) ctrl_q <= dec_legal ? dec : SAFE_CTRL;
        end
    end

`ifdef FLAG_SET_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            setf_q <= 1'b0;
            flags  <= 4'd0;
        end else begin
            if (state == DECODE) setf_q <= dec_legal && dec_setf;
            if (state == EXEC && setf_q) flags <= status;
        end
    end
`else
    logic unused_status;
    assign unused_status = ^status;
    assign flags         = 4'd0;
`endif

    // Control word reaches the Datapath only in EXEC; reset drops it asynchronously via state.
    assign ctrl_out = (state == EXEC) ? ctrl_q : SAFE_CTRL;
    assign SA       = ctrl_out.sa;
    assign SB       = ctrl_out.sb;
    assign DA       = ctrl_out.da;
    assign RegWrite = ctrl_out.regwrite;
    assign MemWrite = ctrl_out.memwrite;
    assign FS       = ctrl_out.fs;
    assign SD       = ctrl_out.sd;
    assign Const    = ctrl_out.konst;
    assign Bsel     = ctrl_out.bsel;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: driver pushes expected retire/illegal records,
// a negedge monitor pops and checks them against the control word seen in EXEC.
module tb_control_sequencer;

    typedef struct packed {
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic        regwrite;
        logic        memwrite;
        logic [4:0]  fs;
        logic        sd;
        logic [63:0] konst;
        logic        bsel;
    } ctrl_t;

    typedef struct {
        logic       ill;
        int         t;
        ctrl_t      c;
        logic [3:0] fl;
    } exp_t;

    localparam ctrl_t SAFE = '{sa: 5'd31, sb: 5'd31, da: 5'd31, regwrite: 1'b0,
                               memwrite: 1'b0, fs: 5'd0, sd: 1'b0, konst: 64'd0, bsel: 1'b0};

    logic        clock, reset;
    logic [31:0] instr;
    logic        instr_valid, instr_ready;
    logic [4:0]  SA, SB, DA, FS;
    logic        RegWrite, MemWrite, SD, Bsel;
    logic [63:0] Const;
    logic [3:0]  status, flags;
    logic        done, illegal;

    control_sequencer dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .SA(SA), .SB(SB), .DA(DA), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .FS(FS), .SD(SD), .Const(Const), .Bsel(Bsel),
        .status(status), .flags(flags), .done(done), .illegal(illegal)
    );

    always #5 clock = ~clock;

    int    cyc = 0;
    int    ntests = 0;
    int    nfail = 0;
    exp_t  q[$];
    logic [3:0] exp_flags = 4'd0;
    ctrl_t act, prev;

    assign act = {SA, SB, DA, RegWrite, MemWrite, FS, SD, Const, Bsel};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    function automatic ctrl_t mk(input logic [4:0] sa, sb, da, input logic rw, mw,
                                 input logic [4:0] fs, input logic sd,
                                 input logic [63:0] k, input logic bsel);
        return '{sa: sa, sb: sb, da: da, regwrite: rw, memwrite: mw, fs: fs, sd: sd,
                 konst: k, bsel: bsel};
    endfunction

    function automatic logic [31:0] rt(input logic [10:0] op, input logic [4:0] rm,
                                       input logic [5:0] sh, input logic [4:0] rn, rd);
        return {op, rm, sh, rn, rd};
    endfunction

    function automatic logic [31:0] it(input logic [9:0] op, input logic [11:0] imm,
                                       input logic [4:0] rn, rd);
        return {op, imm, rn, rd};
    endfunction

    function automatic logic [31:0] dt(input logic [10:0] op, input logic [8:0] imm,
                                       input logic [4:0] rn, rtt);
        return {op, imm, 2'b00, rn, rtt};
    endfunction

    // Monitor: a done pulse retires the instruction whose EXEC word was seen last cycle.
    always @(negedge clock) begin
        exp_t e;
        if (reset && (done || illegal)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 128'({done, illegal}), 128'(0));
            end else begin
                e = q.pop_front();
                chk("kind_cycle", 128'({illegal, done, cyc}), 128'({e.ill, !e.ill, e.t}));
                chk("ctrl_word", 128'(prev), 128'(e.ill ? SAFE : e.c));
                chk("flags", 128'(flags), 128'(e.fl));
                if (e.ill) chk("illegal_no_write", 128'({RegWrite, MemWrite}), 128'(0));
            end
        end
        prev = act;
    end

    task automatic send(input logic [31:0] w, input ctrl_t c, input logic ill, output int hs);
        exp_t e;
        instr       = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 16 && !instr_ready; i++) @(negedge clock);
        hs = cyc;
        if (!instr_ready) begin
            chk("handshake_timeout", 128'(instr_ready), 128'(1));
            instr_valid = 1'b0;
            return;
        end
        e.ill = ill;
        e.t   = cyc + (ill ? 2 : 3);
        e.c   = c;
        e.fl  = exp_flags;
        q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int hs, hs1, hs2;
        clock = 1'b0; reset = 1'b0; instr = '0; instr_valid = 1'b0; status = 4'd0;
        repeat (2) @(negedge clock);
        chk("rst_ctrl", 128'(act), 128'(SAFE));
        chk("rst_ready", 128'(instr_ready), 128'(1));
        chk("rst_pulses_flags", 128'({done, illegal, flags}), 128'(0));
        reset = 1'b1;
        @(negedge clock);

        // ADDI X5,XZR,#24
        send(32'h910063E5, mk(31, 31, 5, 1, 0, 5'b01000, 0, 64'd24, 1), 0, hs);
        idle(4);

        // ADD X1,X5,X7 then EOR X30,X1,X5 with valid held
        send(rt(11'b10001011000, 7, 0, 5, 1), mk(5, 7, 1, 1, 0, 5'b01000, 0, 64'd0, 0), 0, hs1);
        send(rt(11'b11001010000, 5, 0, 1, 30), mk(1, 5, 30, 1, 0, 5'b01100, 0, 64'd0, 0), 0, hs2);
        chk("b2b_gap", 128'(hs2 - hs1), 128'(2));
        idle(4);

        // LDUR X11,[XZR,#-4]; STUR X7,[XZR,#4]
        send(dt(11'b11111000010, 9'h1FC, 31, 11),
             mk(31, 31, 11, 1, 0, 5'b01000, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1), 0, hs);
        send(dt(11'b11111000000, 9'd4, 31, 7), mk(31, 7, 31, 0, 1, 5'b01000, 1, 64'd4, 1), 0, hs);
        idle(4);

        // Remaining ops
        send(rt(11'b11001011000, 2, 0, 4, 3), mk(4, 2, 3, 1, 0, 5'b01001, 0, 64'd0, 0), 0, hs);
        send(rt(11'b10001010000, 11, 0, 10, 9), mk(10, 11, 9, 1, 0, 5'b00000, 0, 64'd0, 0), 0, hs);
        send(rt(11'b10101010000, 14, 0, 13, 12), mk(13, 14, 12, 1, 0, 5'b00100, 0, 64'd0, 0), 0, hs);
        send(it(10'b1101000100, 12'hFFF, 3, 2), mk(3, 31, 2, 1, 0, 5'b01001, 0, 64'hFFF, 1), 0, hs);
        send(rt(11'b11010011011, 5, 63, 7, 6), mk(7, 31, 6, 1, 0, 5'b10000, 0, 64'd63, 1), 0, hs);
        send(rt(11'b11010011010, 0, 1, 9, 8), mk(9, 31, 8, 1, 0, 5'b10100, 0, 64'd1, 1), 0, hs);
        idle(4);

        // Undecodable opcode 0x000
        send(32'h0000_0000, SAFE, 1, hs);
        idle(4);
        send(32'h0000_0000, SAFE, 1, hs);
        send(rt(11'b10001011000, 3, 0, 2, 1), mk(2, 3, 1, 1, 0, 5'b01000, 0, 64'd0, 0), 0, hs);
        idle(4);

        // SUBS X4,X3,X2 then ADD: flag capture and hold
        status = 4'b0001;
`ifdef FLAG_SET_EN
        exp_flags = 4'b0001;
        send(rt(11'b11101011000, 2, 0, 3, 4), mk(3, 2, 4, 1, 0, 5'b01001, 0, 64'd0, 0), 0, hs);
`else
        send(rt(11'b11101011000, 2, 0, 3, 4), SAFE, 1, hs);
`endif
        idle(4);
        status = 4'b1110;
        send(rt(11'b10001011000, 7, 0, 5, 1), mk(5, 7, 1, 1, 0, 5'b01000, 0, 64'd0, 0), 0, hs);
        idle(4);

        // Reset in the middle of a STUR EXEC cycle
        send(dt(11'b11111000000, 9'd4, 31, 7), mk(31, 7, 31, 0, 1, 5'b01000, 1, 64'd4, 1), 0, hs);
        instr_valid = 1'b0;
        for (int i = 0; i < 8 && !MemWrite; i++) @(negedge clock);
        chk("stur_exec_seen", 128'(MemWrite), 128'(1));
        #2 reset = 1'b0;
        q.delete();
        exp_flags = 4'd0;
        #1;
        chk("rst_async_we", 128'({RegWrite, MemWrite}), 128'(0));
        chk("rst_async_ctrl", 128'(act), 128'(SAFE));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", 128'(instr_ready), 128'(1));
        chk("post_rst_state", 128'({act, done, illegal, flags}), 128'({SAFE, 6'd0}));

        send(rt(11'b11001011000, 30, 0, 29, 28), mk(29, 30, 28, 1, 0, 5'b01001, 0, 64'd0, 0), 0, hs);
        idle(5);

        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
